// File: rtl/dm_responder.sv
// dm_responder
//   Memory-side end of the data-memory byte-lane interface. Accepts one
//   word-aligned request at a time, applies the byte-lane write mask to the
//   addressed RAM word, and returns the resulting word after a configurable
//   number of wait states. While an access is outstanding, stall holds the
//   pipeline.
//
// Ports
//   clk         in   1   system clock, rising edge
//   rstn        in   1   synchronous active-low reset
//   req_valid   in   1   request present this cycle
//   req_ready   out  1   responder can accept (IDLE only)
//   req_addr    in   32  byte address; word index = req_addr[31:2]
//   req_we      in   4   byte-lane write mask, 0000 = read
//   req_wdata   in   32  write data already placed in its lanes
//   resp_valid  out  1   one-cycle completion pulse
//   resp_rdata  out  32  word after the access (0 on error)
//   resp_err    out  1   word index out of range
//   stall       out  1   pipeline hold request
module dm_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam int         AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    we_q;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          accept, access;
  logic [31:0]   acc_addr, acc_wdata, merged;
  logic [3:0]    acc_we;
  logic [29:0]   acc_idx;
  logic [AW-1:0] acc_ptr;
  logic          acc_err;

  // Replace only the lanes selected by the mask; other lanes keep old data.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  we);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  // With zero wait states the access happens on the accept edge itself, so
  // the live request inputs feed the access path; otherwise the latched copy.
  always_comb begin
    accept    = (state_q == IDLE) && req_valid;
    access    = (accept && (WAIT_L == 4'd0)) ||
                ((state_q == WAIT) && (cnt_q <= 4'd1));
    acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    acc_we    = (state_q == IDLE) ? req_we    : we_q;
    acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    acc_idx   = acc_addr[31:2];
    acc_ptr   = acc_idx[AW-1:0];
    acc_err   = ({2'b00, acc_idx} >= 32'(DEPTH_WORDS));
    merged    = merge_lanes(mem_q[acc_ptr], acc_wdata, acc_we);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    stall      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          stall   = 1'b1;
          cnt_d   = WAIT_L;
          state_d = (WAIT_L == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (access) begin
        resp_err   <= acc_err;
        resp_rdata <= acc_err ? 32'd0 : merged;
      end
    end
  end

  // Request capture carries no reset: it is only consumed after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr;
      we_q    <= req_we;
      wdata_q <= req_wdata;
    end
  end

  // RAM survives reset; a reset on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rstn && access && !acc_err) mem_q[acc_ptr] <= merged;
  end

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_we;
  logic        resp_valid, resp_err, stall;
  logic [31:0] resp_rdata;

  logic        v0, rdy0, rv0, err0, st0;
  logic [31:0] a0, wd0, rd0;
  logic [3:0]  we0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dm_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .stall(stall));

  dm_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rstn(rstn), .req_valid(v0), .req_ready(rdy0),
    .req_addr(a0), .req_we(we0), .req_wdata(wd0),
    .resp_valid(rv0), .resp_rdata(rd0), .resp_err(err0),
    .stall(st0));

  // Drive one request on the main DUT and wait (bounded) for its response.
  task automatic xact(input logic [31:0] a, input logic [3:0] we,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic e, output bit ok);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = wd;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); #1; n++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFC; req_we = 4'hF; req_wdata = 32'h0;
    #1;
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); #1; n++; end
    ok = resp_valid;
    rd = resp_rdata;
    e  = resp_err;
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_valid = 1'b0; req_addr = 0; req_we = 0; req_wdata = 0;
    v0 = 1'b0; a0 = 0; we0 = 0; wd0 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", resp_valid); else n_pass++;
    n_checks++; if (resp_rdata !== 32'd0) $display("FAIL rst_rdata: got %h want 0", resp_rdata); else n_pass++;
    n_checks++; if (resp_err !== 1'b0) $display("FAIL rst_err: got %b want 0", resp_err); else n_pass++;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", req_ready); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall); else n_pass++;
    rstn = 1'b1;
  endtask

  task automatic preload();
    logic [31:0] rd; logic e; bit ok;
    logic [31:0] addrs [4] = '{32'h14, 32'hC, 32'h0, 32'h1C};
    logic [31:0] vals  [4] = '{32'hCAFEBABE, 32'h11223344, 32'h01020304, 32'h77777777};
    for (int i = 0; i < 4; i++) begin
      xact(addrs[i], 4'hF, vals[i], rd, e, ok);
      n_checks++;
      if (!ok || rd !== vals[i] || e !== 1'b0)
        $display("FAIL preload%0d: got ok=%b rdata=%h err=%b want rdata=%h err=0", i, ok, rd, e, vals[i]);
      else n_pass++;
    end
  endtask

  task automatic test_read_latency();
    // cycle N: request presented and accepted
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h14; req_we = 4'h0; req_wdata = 32'h0;
    #1;
    n_checks++; if (stall !== 1'b1 || req_ready !== 1'b1) $display("FAIL lat_N: got stall=%b ready=%b want 1 1", stall, req_ready); else n_pass++;
    // inputs changed after acceptance must not matter
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      req_valid = 1'b0; req_addr = 32'h0; req_we = 4'hF; req_wdata = 32'hFFFF_FFFF;
      #1;
      n_checks++;
      if (stall !== 1'b1 || req_ready !== 1'b0 || resp_valid !== 1'b0)
        $display("FAIL lat_N+%0d: got stall=%b ready=%b rv=%b want 1 0 0", c, stall, req_ready, resp_valid);
      else n_pass++;
    end
    @(negedge clk); #1;
    n_checks++;
    if (resp_valid !== 1'b1 || stall !== 1'b0 || resp_rdata !== 32'hCAFEBABE || resp_err !== 1'b0)
      $display("FAIL lat_N+3: got rv=%b stall=%b rdata=%h err=%b want 1 0 cafebabe 0", resp_valid, stall, resp_rdata, resp_err);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'hCAFEBABE)
      $display("FAIL lat_hold: got rv=%b rdata=%h want 0 cafebabe", resp_valid, resp_rdata);
    else n_pass++;
  endtask

  task automatic test_byte_write();
    logic [31:0] rd; logic e; bit ok;
    xact(32'hC, 4'b0100, 32'h00AA0000, rd, e, ok);
    n_checks++; if (!ok || rd !== 32'h11AA3344 || e !== 1'b0) $display("FAIL bw_lane2: got ok=%b rdata=%h err=%b want 11aa3344", ok, rd, e); else n_pass++;
    xact(32'hE, 4'b0000, 32'h0, rd, e, ok);
    n_checks++; if (!ok || rd !== 32'h11AA3344) $display("FAIL bw_readback: got ok=%b rdata=%h want 11aa3344", ok, rd); else n_pass++;
    xact(32'hC, 4'b0101, 32'h00BB00CC, rd, e, ok);
    n_checks++; if (!ok || rd !== 32'h11BB33CC) $display("FAIL bw_0101: got ok=%b rdata=%h want 11bb33cc", ok, rd); else n_pass++;
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic e; bit ok;
    xact(32'h00001000, 4'hF, 32'hDEADBEEF, rd, e, ok);
    n_checks++; if (!ok || rd !== 32'h0 || e !== 1'b1) $display("FAIL oor: got ok=%b rdata=%h err=%b want 0 1", ok, rd, e); else n_pass++;
    xact(32'h0, 4'h0, 32'h0, rd, e, ok);
    n_checks++; if (!ok || rd !== 32'h01020304 || e !== 1'b0) $display("FAIL oor_ram0: got ok=%b rdata=%h err=%b want 01020304 0", ok, rd, e); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr [4] = '{32'h28, 32'h28, 32'h28, 32'h28};
    logic [3:0]  we   [4] = '{4'hF, 4'h0, 4'b0011, 4'h0};
    logic [31:0] wd   [4] = '{32'hA5A5A5A5, 32'h0, 32'h00001234, 32'h0};
    logic [31:0] exp  [4] = '{32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A51234, 32'hA5A51234};
    int acc_cyc [4];
    int k = 0, r = 0;
    for (int cyc = 0; cyc < 40 && r < 4; cyc++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = addr[(k < 4) ? k : 3]; req_we = we[(k < 4) ? k : 3]; req_wdata = wd[(k < 4) ? k : 3];
      if (k >= 4) req_valid = 1'b0;
      #1;
      if (resp_valid) begin
        n_checks++;
        if (resp_rdata !== exp[r]) $display("FAIL b2b_resp%0d: got %h want %h", r, resp_rdata, exp[r]); else n_pass++;
        r++;
      end
      if (req_ready && req_valid) begin acc_cyc[k] = cyc; k++; end
    end
    req_valid = 1'b0;
    n_checks++; if (r !== 4 || k !== 4) $display("FAIL b2b_count: got resp=%0d acc=%0d want 4 4", r, k); else n_pass++;
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if (i < k && acc_cyc[i] - acc_cyc[i-1] !== 4)
        $display("FAIL b2b_spacing%0d: got %0d want 4", i, acc_cyc[i] - acc_cyc[i-1]);
      else n_pass++;
    end
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk); #1;
      n_checks++; if (resp_valid !== 1'b0) $display("FAIL b2b_extra: got rv=%b want 0", resp_valid); else n_pass++;
    end
  endtask

  task automatic test_reset_during_wait();
    logic [31:0] rd; logic e; bit ok;
    bit seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h1C; req_we = 4'hF; req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    req_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0 || req_ready !== 1'b1 || stall !== 1'b0)
      $display("FAIL rwait_outs: got rv=%b rdata=%h err=%b ready=%b stall=%b want 0 0 0 1 0",
               resp_valid, resp_rdata, resp_err, req_ready, stall);
    else n_pass++;
    rstn = 1'b1;
    for (int c = 0; c < 5; c++) begin @(negedge clk); #1; if (resp_valid) seen = 1; end
    n_checks++; if (seen) $display("FAIL rwait_noresp: got resp_valid=1 want 0"); else n_pass++;
    xact(32'h1C, 4'h0, 32'h0, rd, e, ok);
    n_checks++; if (!ok || rd !== 32'h77777777) $display("FAIL rwait_ram7: got ok=%b rdata=%h want 77777777", ok, rd); else n_pass++;
  endtask

  task automatic test_zero_wait();
    logic [31:0] addrs [2] = '{32'h8, 32'h8};
    logic [3:0]  wes   [2] = '{4'hF, 4'h0};
    logic [31:0] wds   [2] = '{32'h5A5A0F0F, 32'h0};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      v0 = 1'b1; a0 = addrs[i]; we0 = wes[i]; wd0 = wds[i];
      #1;
      n_checks++; if (st0 !== 1'b1 || rdy0 !== 1'b1) $display("FAIL zw%0d_accept: got stall=%b ready=%b want 1 1", i, st0, rdy0); else n_pass++;
      @(negedge clk);
      v0 = 1'b0;
      #1;
      n_checks++;
      if (rv0 !== 1'b1 || st0 !== 1'b0 || rd0 !== 32'h5A5A0F0F || err0 !== 1'b0)
        $display("FAIL zw%0d_resp: got rv=%b stall=%b rdata=%h err=%b want 1 0 5a5a0f0f 0", i, rv0, st0, rd0, err0);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_read_latency();
    test_byte_write();
    test_out_of_range();
    test_back_to_back();
    test_reset_during_wait();
    test_zero_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
